// File: rtl/ball_controller.sv
// Per-frame ball motion, clamping and countdown/play/win/lose sequencing for the display stage.
// Define BALL_CTRL_LIVES_EN to enable the lives counter; otherwise any collision loses the game.
module ball_controller #(
    parameter int START_ROW        = 40,
    parameter int START_COL        = 40,
    parameter int STEP             = 2,
    parameter int BALL_RADIUS      = 8,
    parameter int SCREEN_W         = 640,
    parameter int SCREEN_H         = 480,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int LIVES            = 3
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [1:0]  collision,
    input  logic [1:0]  touchdown,
    output logic [31:0] currentBallRow,
    output logic [31:0] currentBallCol,
    output logic        change,
    output logic        countdown,
    output logic        win,
    output logic        lose,
    output logic [1:0]  lives_left
);

    localparam int CNT_W = $clog2(COUNTDOWN_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [31:0]       START_ROW_V = 32'(START_ROW);
    localparam logic [31:0]       START_COL_V = 32'(START_COL);
    localparam logic signed [32:0] STEP_V     = 33'(STEP);
    localparam logic signed [32:0] ROW_MIN    = 33'(BALL_RADIUS);
    localparam logic signed [32:0] ROW_MAX    = 33'(SCREEN_H - 1 - BALL_RADIUS);
    localparam logic signed [32:0] COL_MIN    = 33'(BALL_RADIUS);
    localparam logic signed [32:0] COL_MAX    = 33'(SCREEN_W - 1 - BALL_RADIUS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_PLAY,
        S_WIN,
        S_LOSE
    } state_t;

    state_t           state_reg;
    logic [31:0]      row_reg;
    logic [31:0]      col_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             hit_reg;
    logic             goal_reg;
    logic             change_reg;
    logic             countdown_reg;
    logic             win_reg;
    logic             lose_reg;

    logic             hit_now;
    logic             goal_now;
    logic             hit_fatal;
    logic             respawn_moves;
    logic signed [32:0] row_ext, col_ext, row_step, col_step, row_next, col_next;

    // Flags include the current cycle so a hit on the frame_tick cycle still counts.
    assign hit_now  = hit_reg  | (|collision);
    assign goal_now = goal_reg | (|touchdown);
    assign respawn_moves = (row_reg != START_ROW_V) || (col_reg != START_COL_V);

    always_comb begin
        row_ext  = signed'({1'b0, row_reg});
        col_ext  = signed'({1'b0, col_reg});
        row_step = row_ext;
        col_step = col_ext;
        if (btn_up && !btn_down)
            row_step = row_ext - STEP_V;
        else if (btn_down && !btn_up)
            row_step = row_ext + STEP_V;
        if (btn_left && !btn_right)
            col_step = col_ext - STEP_V;
        else if (btn_right && !btn_left)
            col_step = col_ext + STEP_V;

        row_next = row_step;
        if (row_step < ROW_MIN)
            row_next = ROW_MIN;
        else if (row_step > ROW_MAX)
            row_next = ROW_MAX;
        col_next = col_step;
        if (col_step < COL_MIN)
            col_next = COL_MIN;
        else if (col_step > COL_MAX)
            col_next = COL_MAX;
    end

`ifdef BALL_CTRL_LIVES_EN
    logic [1:0] lives_reg;
    assign hit_fatal  = (lives_reg <= 2'd1);
    assign lives_left = lives_reg;

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            lives_reg <= 2'(LIVES);
        end else begin
            case (state_reg)
                S_IDLE, S_WIN, S_LOSE:
                    if (start)
                        lives_reg <= 2'(LIVES);
                S_PLAY:
                    if (frame_tick && hit_now && lives_reg != 2'd0)
                        lives_reg <= lives_reg - 2'd1;
                default: ;
            endcase
        end
    end
`else
    // Without lives tracking the count parameter has no effect and the output reads zero.
    assign hit_fatal  = 1'b1;
    assign lives_left = 2'(LIVES) & 2'b00;
`endif

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            row_reg       <= START_ROW_V;
            col_reg       <= START_COL_V;
            frame_cnt_reg <= '0;
            hit_reg       <= 1'b0;
            goal_reg      <= 1'b0;
            change_reg    <= 1'b0;
            countdown_reg <= 1'b0;
            win_reg       <= 1'b0;
            lose_reg      <= 1'b0;
        end else begin
            change_reg <= 1'b0;
            hit_reg    <= 1'b0;
            goal_reg   <= 1'b0;
            case (state_reg)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state_reg     <= S_COUNTDOWN;
                        countdown_reg <= 1'b1;
                        win_reg       <= 1'b0;
                        lose_reg      <= 1'b0;
                        frame_cnt_reg <= '0;
                        row_reg       <= START_ROW_V;
                        col_reg       <= START_COL_V;
                        change_reg    <= respawn_moves;
                    end
                end
                S_COUNTDOWN: begin
                    if (frame_tick) begin
                        if (frame_cnt_reg == CNT_LAST) begin
                            state_reg     <= S_PLAY;
                            countdown_reg <= 1'b0;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                S_PLAY: begin
                    if (!frame_tick) begin
                        hit_reg  <= hit_now;
                        goal_reg <= goal_now;
                    end else if (hit_now) begin
                        if (hit_fatal) begin
                            state_reg <= S_LOSE;
                            lose_reg  <= 1'b1;
                        end else begin
                            state_reg     <= S_COUNTDOWN;
                            countdown_reg <= 1'b1;
                            frame_cnt_reg <= '0;
                            row_reg       <= START_ROW_V;
                            col_reg       <= START_COL_V;
                            change_reg    <= respawn_moves;
                        end
                    end else if (goal_now) begin
                        state_reg <= S_WIN;
                        win_reg   <= 1'b1;
                    end else begin
                        row_reg    <= row_next[31:0];
                        col_reg    <= col_next[31:0];
                        change_reg <= (row_next[31:0] != row_reg) || (col_next[31:0] != col_reg);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign currentBallRow = row_reg;
    assign currentBallCol = col_reg;
    assign change         = change_reg;
    assign countdown      = countdown_reg;
    assign win            = win_reg;
    assign lose           = lose_reg;

endmodule

// File: doc/ball_controller.md
# ball_controller

Game-state and ball-motion controller that sits directly upstream of the screen display stage. Once per frame it moves the ball from the direction buttons, clamps the ball to the screen, and evaluates the collision and touchdown flags the display raised during that frame. It drives the display's ball position, `change`, `countdown`, `win` and `lose` inputs, and it runs a countdown → play → win/lose state machine with a lives counter.

## Interface
Parameters:
- `START_ROW`, 40: ball-centre row after reset and after each respawn.
- `START_COL`, 40: ball-centre column after reset and after each respawn.
- `STEP`, 2: pixels moved per frame per axis.
- `BALL_RADIUS`, 8: clamp margin from each screen edge.
- `SCREEN_W`, 640: screen width in pixels.
- `SCREEN_H`, 480: screen height in pixels.
- `COUNTDOWN_FRAMES`, 180: frames spent in COUNTDOWN before PLAY.
- `LIVES`, 3: lives loaded on start.

Ports:
- `pixel_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse, once per frame, after the last visible pixel.
- `start` in 1: one-cycle pulse; starts or restarts a game.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: synchronised level inputs.
- `collision` in 2: from the display; nonzero means the ball overlaps a barrier on the current pixel.
- `touchdown` in 2: from the display; nonzero means the ball overlaps the endzone on the current pixel.
- `currentBallRow` out 32: ball-centre row.
- `currentBallCol` out 32: ball-centre column.
- `change` out 1: one-cycle pulse when the position register changes value.
- `countdown` out 1: high while in COUNTDOWN.
- `win` out 1: high while in WIN.
- `lose` out 1: high while in LOSE.
- `lives_left` out 2: remaining lives.

## Operation
- States and transitions:
  - IDLE → COUNTDOWN on `start`.
  - COUNTDOWN → PLAY once `COUNTDOWN_FRAMES` frame_ticks have been counted.
  - PLAY → COUNTDOWN, LOSE or WIN at frame evaluation, per the rules below.
  - WIN or LOSE → COUNTDOWN on `start`.
- `start` is ignored in COUNTDOWN and PLAY.
- Entering COUNTDOWN:
  - position is loaded with (`START_ROW`, `START_COL`);
  - the frame counter is cleared;
  - entry from IDLE, WIN or LOSE reloads `lives_left` = `LIVES`.
- Sticky flags:
  - `hit` latches when `collision` != 0; `goal` latches when `touchdown` != 0.
  - Both sample every cycle in PLAY, including the `frame_tick` cycle.
  - Both clear on the cycle after each evaluation, and are held clear outside PLAY.
- PLAY evaluation on `frame_tick`, in priority order:
  1. `hit`: decrement `lives_left`. If the result is 0, go to LOSE. Otherwise go to COUNTDOWN and respawn.
  2. `goal`: go to WIN.
  3. Neither: move the ball.
- Collision beats touchdown when both are set in the same frame.
- Movement, per axis:
  - up only: row −= `STEP`; down only: row += `STEP`;
  - left only: col −= `STEP`; right only: col += `STEP`;
  - both or neither button on an axis: no motion on that axis.
  - Both axes may move in the same frame (diagonal).
- Clamping:
  - row is held in [`BALL_RADIUS`, `SCREEN_H`−1−`BALL_RADIUS`] = [8, 471];
  - col is held in [`BALL_RADIUS`, `SCREEN_W`−1−`BALL_RADIUS`] = [8, 631].
  - Arithmetic is signed 33-bit, so a decrement never wraps.
- Position holds constant in WIN, LOSE and IDLE.
- `change` fires only when the row or column actually changes. This covers respawn moves. Clamped or no-button frames do not pulse it.

## Timing
- Reset values:
  - state IDLE;
  - `currentBallRow` = `START_ROW`, `currentBallCol` = `START_COL`;
  - `change` = 0, `countdown` = 0, `win` = 0, `lose` = 0;
  - `lives_left` = `LIVES`;
  - sticky flags and frame counter = 0.
- Reset mid-game aborts immediately, whatever the state.
- All outputs are registered. The new position, the new state outputs and the `change` pulse all appear on the cycle after the `frame_tick` or `start` that caused them.
- `countdown` rises on the cycle after `start`. It falls on the cycle after the `COUNTDOWN_FRAMES`-th frame_tick.
- The first move happens at the next frame_tick after entering PLAY.
- `collision` asserted on the same cycle as `frame_tick` counts toward that frame's evaluation.
- `start` coincident with `frame_tick` in WIN or LOSE: `start` wins.

## Configuration
- Macro `BALL_CTRL_LIVES_EN`.
- Defined: lives behaviour as described above.
- Undefined:
  - there is no lives counter and `lives_left` is tied to 0;
  - any PLAY collision goes straight to LOSE with no respawn;
  - the `LIVES` parameter is ignored.

## Test plan
- Reset, then `start`, then 180 frame_ticks → `countdown` is high for exactly 180 frames; row/col = 40/40, `lives_left` = 3.
- PLAY, `btn_right` held for 10 frames → col = 60, row = 40, exactly 10 `change` pulses.
- PLAY, `btn_left` and `btn_up` held for 30 frames from (40,40) → row and col stop at 8, and `change` stops once both are clamped. Up+down held together → row unchanged.
- Collision pulsed in three separate PLAY frames (macro defined) → the first two respawn at (40,40) with `lives_left` = 2 then 1, each followed by countdown; the third raises `lose` with `lives_left` = 0. Macro undefined → the first collision raises `lose`.
- Collision and touchdown in the same frame → COUNTDOWN with `lives_left` decremented, and `win` stays 0. Touchdown alone → `win` is high on the next cycle and position is frozen; `start` → COUNTDOWN with `lives_left` = 3.
- `reset` asserted mid-countdown and asynchronously to `pixel_clk` → all outputs return to their reset values immediately, and `start` is required again.
